// File: rtl/shannon_lpf_pkg.sv
// Shared definitions for the shannon_whitaker_lpf streaming half-band FIR.
// Holds the datapath geometry, the sample and accumulator types, the Q1.14
// half-band coefficients and the round/saturate helper that every lane uses.
package shannon_lpf_pkg;

  localparam int NSAMP      = 8;   // samples per clock, lane 0 earliest in time
  localparam int NBITS      = 12;  // signed sample width, input and output
  localparam int COEFF_FRAC = 14;  // coefficients are Q1.14
  localparam int NTAPS      = 15;
  localparam int HALF       = (NTAPS - 1) / 2;  // centre tap offset in a window

  // Centre product plus one pre-added product per odd tap pair.
  localparam int NPROD = 1 + (HALF + 1) / 2;

  // Sample (12) + coefficient (15) + growth of the five-term sum (2).
  localparam int ACC_W = NBITS + 15 + 2;

  localparam int ROUND_ADD = 1 << (COEFF_FRAC - 1);
  localparam int SAT_MAX   = (1 << (NBITS - 1)) - 1;
  localparam int SAT_MIN   = -(1 << (NBITS - 1));

  typedef logic signed [NBITS-1:0] sample_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // h[k] for k = 0..7; h[-k] = h[k]. Even taps other than the centre are zero.
  localparam int H [0:HALF] = '{8192, 5215, 0, -1738, 0, 1043, 0, -745};

  // Round half-up to the sample grid, then clip to the signed output range.
  function automatic sample_t round_sat(input acc_t sum);
    acc_t    shifted;
    sample_t res;
    shifted = (sum + acc_t'(ROUND_ADD)) >>> COEFF_FRAC;
    if (shifted > acc_t'(SAT_MAX)) begin
      res = sample_t'(SAT_MAX);
    end else if (shifted < acc_t'(SAT_MIN)) begin
      res = sample_t'(SAT_MIN);
    end else begin
      res = sample_t'(shifted);
    end
    return res;
  endfunction

endpackage

// File: rtl/swlpf_lane.sv
// One output lane of the half-band FIR.
// Takes the 15-sample window centred on this lane's sample, pre-adds the
// symmetric tap pairs, multiplies by the coefficients, registers the
// products, then sums, rounds, saturates and registers the result.
// Two register stages: products, then the final sample.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   win_i   15 signed samples, element i = x[n-7+i] at win_i[12*i +: 12]
//   out_o   filtered sample y[n], signed
module swlpf_lane
  import shannon_lpf_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NTAPS*NBITS-1:0] win_i,
  output logic [NBITS-1:0]       out_o
);

  sample_t win    [NTAPS];
  acc_t    prod_d [NPROD];
  acc_t    prod_q [NPROD];
  acc_t    sum;
  sample_t out_d;
  sample_t out_q;

  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      win[i] = sample_t'(win_i[NBITS*i +: NBITS]);
    end
  end

  // Product p >= 1 covers tap pair k = 2p-1; the zero even taps are skipped.
  always_comb begin
    prod_d[0] = acc_t'(win[HALF]) * acc_t'(H[0]);
    for (int p = 1; p < NPROD; p++) begin
      prod_d[p] = (acc_t'(win[HALF-(2*p-1)]) + acc_t'(win[HALF+(2*p-1)]))
                  * acc_t'(H[2*p-1]);
    end
  end

  // NOTE: pipeline registers (unlike RAM-style storage) are cleared by the
  // reset, so a reset immediately zeroes everything downstream of them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NPROD; p++) begin
        prod_q[p] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment in clocked blocks, so every register
      // samples its pre-edge inputs regardless of statement order.
      for (int p = 0; p < NPROD; p++) begin
        prod_q[p] <= prod_d[p];
      end
    end
  end

  // NOTE: sum gets its default before the loop, so no path leaves it
  // unassigned (no latch); blocking accumulation is intended here.
  always_comb begin
    sum = '0;
    for (int p = 0; p < NPROD; p++) begin
      sum = sum + prod_q[p];
    end
    out_d = round_sat(sum);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/shannon_whitaker_lpf.sv
// Streaming 15-tap half-band low-pass FIR, 8 samples per clock.
// Keeps three blocks of history (previous, current, next) so every lane of
// the current block sees its full +/-7 sample neighbourhood across block
// boundaries, and hands each lane its window. Total latency: a block taken
// on edge E appears on out_o after edge E+3.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset, clears history and outputs
//   in_i    8 signed 12-bit samples, lane j at in_i[12*j +: 12]
//   out_o   8 signed 12-bit filtered samples, lane j at out_o[12*j +: 12]
module shannon_whitaker_lpf
  import shannon_lpf_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NSAMP*NBITS-1:0] in_i,
  output logic [NSAMP*NBITS-1:0] out_o
);

  localparam int BLK_W  = NSAMP * NBITS;
  localparam int PRV_W  = (NSAMP - 1) * NBITS;  // lane 0 of the previous block is never needed
  localparam int HIST_N = 3 * NSAMP - 2;        // samples visible to the lane windows

  logic [BLK_W-1:0]        nxt_d, nxt_q;
  logic [BLK_W-1:0]        cur_d, cur_q;
  logic [PRV_W-1:0]        prv_d, prv_q;
  logic [HIST_N*NBITS-1:0] hist;

  always_comb begin
    nxt_d = in_i;
    cur_d = nxt_q;
    prv_d = cur_q[BLK_W-1:NBITS];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nxt_q <= '0;
      cur_q <= '0;
      prv_q <= '0;
    end else begin
      nxt_q <= nxt_d;
      cur_q <= cur_d;
      prv_q <= prv_d;
    end
  end

  // Index 0 = previous lane 1; current lane j sits at index NSAMP-1+j, so its
  // window of NTAPS samples starts at index j.
  assign hist = {nxt_q[PRV_W-1:0], cur_q, prv_q};

  for (genvar j = 0; j < NSAMP; j++) begin : g_lane
    swlpf_lane u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .win_i  (hist[NBITS*j +: NTAPS*NBITS]),
      .out_o  (out_o[NBITS*j +: NBITS])
    );
  end

endmodule

// File: tb/tb_shannon_whitaker_lpf.sv
// Self-checking bench for shannon_whitaker_lpf: drives one block per clock,
// records the sample stream and compares every output lane against a direct
// convolution of that stream with the half-band kernel.
module tb_shannon_whitaker_lpf;

  localparam int NS   = 8;
  localparam int NB   = 12;
  localparam int BW   = NS * NB;
  localparam int XMAX = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] in_blk;
  logic [BW-1:0] out_blk;

  shannon_whitaker_lpf dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .in_i   (in_blk),
    .out_o  (out_blk)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int xs [0:XMAX-1];  // sample stream since the last reset, global index n
  int nx = 0;         // number of samples recorded

  int h_tab [0:7] = '{8192, 5215, 0, -1738, 0, 1043, 0, -745};

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int x_at(input int n);
    if (n < 0 || n >= nx) return 0;
    return xs[n];
  endfunction

  // y[n] = round_half_up(sum h[k] x[n-k] / 2^14), clipped to 12 bits.
  function automatic int y_ref(input int n);
    longint s;
    s = 0;
    for (int k = -7; k <= 7; k++) begin
      s += longint'(h_tab[(k < 0) ? -k : k]) * longint'(x_at(n - k));
    end
    s = (s + 8192) >>> 14;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    return int'(s);
  endfunction

  function automatic int lane_of(input logic [BW-1:0] b, input int j);
    logic signed [NB-1:0] t;
    t = b[NB*j +: NB];
    return int'(t);
  endfunction

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int j, input int v);
    b[NB*j +: NB] = NB'(v);
    return b;
  endfunction

  // Drive one block, clock it in, then check the block that left the pipe
  // (three blocks older than the one just driven).
  task automatic step(input string tag, input logic [BW-1:0] blk, output logic [BW-1:0] ob);
    int bi;
    in_blk = blk;
    for (int j = 0; j < NS; j++) xs[nx+j] = lane_of(blk, j);
    nx += NS;
    bi = nx / NS - 1;
    @(posedge clk);
    #1;
    for (int j = 0; j < NS; j++) begin
      check($sformatf("%s_b%0d_l%0d", tag, bi - 3, j), lane_of(out_blk, j),
            y_ref(NS * (bi - 3) + j));
    end
    ob = out_blk;
  endtask

  initial begin
    logic [BW-1:0] ob;
    logic [BW-1:0] b;
    int            pat [0:23];

    rst_n  = 1'b0;
    in_blk = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_init", $countones(out_blk), 0);
    rst_n = 1'b1;

    // Random warm-up so the pipeline holds nonzero data.
    repeat (8) begin
      for (int j = 0; j < NS; j++) b = put(b, j, int'($urandom_range(4095)) - 2048);
      step("warm", b, ob);
    end

    // Asynchronous reset mid-stream.
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", $countones(out_blk), 0);
    in_blk = '0;
    nx     = 0;
    @(posedge clk);
    #1;
    check("rst_hold", $countones(out_blk), 0);
    rst_n = 1'b1;
    repeat (5) step("rst_zero", '0, ob);

    // Positive and negative impulses on every lane.
    for (int s = 1; s >= -1; s -= 2) begin
      for (int j = 0; j < NS; j++) begin
        step("imp", put('0, j, 1000 * s), ob);
        step("imp_z", '0, ob);
        step("imp_z", '0, ob);
        step("imp_z", '0, ob);
        check($sformatf("imp_ctr_s%0d_l%0d", s, j), lane_of(ob, j), 500 * s);
        step("imp_z", '0, ob);
      end
    end

    // Adjacent pairs.
    for (int j = 0; j < NS - 1; j++) begin
      step("pair", put(put('0, j, 1000), j + 1, 1000), ob);
      step("pair_z", '0, ob);
      step("pair_z", '0, ob);
      step("pair_z", '0, ob);
      check($sformatf("pair_ctr_l%0d", j), lane_of(ob, j), 818);
      check($sformatf("pair_ctr_l%0d", j + 1), lane_of(ob, j + 1), 818);
      step("pair_z", '0, ob);
    end

    // All lanes 1000 for one block.
    b = '0;
    for (int j = 0; j < NS; j++) b = put(b, j, 1000);
    step("all", b, ob);
    repeat (4) step("all_z", '0, ob);

    // Continuous DC at full scale.
    b = '0;
    for (int j = 0; j < NS; j++) b = put(b, j, 2047);
    repeat (8) step("dc", b, ob);
    check("dc_ss", lane_of(ob, 3), 1967);
    repeat (4) step("dc_z", '0, ob);

    // Worst-case pattern around lane 4 of the middle block: x[n-k] = 2047*sign(h[k]).
    for (int s = 1; s >= -1; s -= 2) begin
      for (int i = 0; i < 24; i++) pat[i] = 0;
      for (int k = -7; k <= 7; k++) begin
        pat[12-k] = s * ((h_tab[(k < 0) ? -k : k] < 0) ? -2047 : 2047);
      end
      for (int q = 0; q < 3; q++) begin
        b = '0;
        for (int j = 0; j < NS; j++) b = put(b, j, pat[NS*q+j]);
        step("sat", b, ob);
      end
      step("sat_z", '0, ob);
      step("sat_z", '0, ob);
      check($sformatf("sat_s%0d", s), lane_of(ob, 4), (s > 0) ? 2047 : -2048);
      step("sat_z", '0, ob);
      step("sat_z", '0, ob);
    end

    // Random stream: full-range samples, alternated with large-amplitude runs.
    for (int r = 0; r < 80; r++) begin
      for (int j = 0; j < NS; j++) begin
        if (r % 16 < 8) b = put(b, j, int'($urandom_range(4095)) - 2048);
        else b = put(b, j, ($urandom_range(1) != 0) ? 2047 - int'($urandom_range(7))
                                                  : -2048 + int'($urandom_range(7)));
      end
      step("rnd", b, ob);
    end
    repeat (4) step("rnd_z", '0, ob);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
